serial_crossbar: RTL and testbench

- Parametrised, registered successor to the 2-master/3-slave combinational bit-serial bus interconnect.
- Routes the serial lines valid, last, wD and control from one of NUM_MASTERS masters to one of NUM_SLAVES slaves. Routes ready and rD back from that slave.
- A connection is opened by an arbiter request. It is held by an internal state machine and closed by the master's last beat or an inactivity timeout.
- Sits between the bus arbiter and the master/slave serial ports.

---
 rtl/serial_crossbar.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_crossbar.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_crossbar.sv
// Registered bit-serial crossbar: an arbiter request links one master to one slave,
// and the link is held until the master's last beat or an inactivity timeout.
module serial_crossbar #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int TIMEOUT     = 64,
   parameter int SEL_W       = 3
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   req,
   input  logic [SEL_W-1:0]       master_sel,
   input  logic [SEL_W-1:0]       slave_sel,
   output logic                   ack,
   output logic                   sel_err,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout,
   input  logic [NUM_MASTERS-1:0] m_valid,
   input  logic [NUM_MASTERS-1:0] m_last,
   input  logic [NUM_MASTERS-1:0] m_wD,
   input  logic [NUM_MASTERS-1:0] m_control,
   output logic [NUM_MASTERS-1:0] m_ready,
   output logic [NUM_MASTERS-1:0] m_rD,
   output logic [NUM_SLAVES-1:0]  s_valid,
   output logic [NUM_SLAVES-1:0]  s_last,
   output logic [NUM_SLAVES-1:0]  s_wD,
   output logic [NUM_SLAVES-1:0]  s_control,
   input  logic [NUM_SLAVES-1:0]  s_ready,
   input  logic [NUM_SLAVES-1:0]  s_rD
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONNECT = 2'd1;
   localparam logic [1:0] ST_ACTIVE  = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [SEL_W-1:0] NM_C      = SEL_W'(NUM_MASTERS);
   localparam logic [SEL_W-1:0] NS_C      = SEL_W'(NUM_SLAVES);

   logic [1:0]             state_q, state_d;
   logic [SEL_W-1:0]       ms_q, ms_d;
   logic [SEL_W-1:0]       sl_q, sl_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   to_flag_q, to_flag_d;
   logic                   ack_q, ack_d;
   logic                   sel_err_q, sel_err_d;
   logic [NUM_SLAVES-1:0]  s_valid_q, s_valid_d;
   logic [NUM_SLAVES-1:0]  s_last_q, s_last_d;
   logic [NUM_SLAVES-1:0]  s_wd_q, s_wd_d;
   logic [NUM_SLAVES-1:0]  s_control_q, s_control_d;
   logic [NUM_MASTERS-1:0] m_ready_q, m_ready_d;
   logic [NUM_MASTERS-1:0] m_rd_q, m_rd_d;

   logic sel_valid, sel_last, sel_wd, sel_control;
   logic sel_ready, sel_rd;
   logic idx_ok;

   // Pick out the lines of the linked master and slave; unlinked ports never reach the datapath.
   always_comb begin
      sel_valid   = 1'b0;
      sel_last    = 1'b0;
      sel_wd      = 1'b0;
      sel_control = 1'b0;
      sel_ready   = 1'b0;
      sel_rd      = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (ms_q == SEL_W'(i + 1)) begin
            sel_valid   = m_valid[i];
            sel_last    = m_last[i];
            sel_wd      = m_wD[i];
            sel_control = m_control[i];
         end
      end
      for (int j = 0; j < NUM_SLAVES; j++) begin
         if (sl_q == SEL_W'(j + 1)) begin
            sel_ready = s_ready[j];
            sel_rd    = s_rD[j];
         end
      end
   end

   assign idx_ok = (master_sel != '0) && (master_sel <= NM_C) &&
                   (slave_sel  != '0) && (slave_sel  <= NS_C);

   // NOTE: every _d gets a default before the case so no path leaves a signal unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      ms_d        = ms_q;
      sl_d        = sl_q;
      cnt_d       = cnt_q;
      to_flag_d   = to_flag_q;
      ack_d       = 1'b0;
      sel_err_d   = 1'b0;
      s_valid_d   = s_valid_q;
      s_last_d    = s_last_q;
      s_wd_d      = s_wd_q;
      s_control_d = s_control_q;
      m_ready_d   = m_ready_q;
      m_rd_d      = m_rd_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d     = '0;
            to_flag_d = 1'b0;
            if (req) begin
               if (idx_ok) begin
                  ms_d    = master_sel;
                  sl_d    = slave_sel;
                  ack_d   = 1'b1;
                  state_d = ST_CONNECT;
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end

         ST_CONNECT: begin
            cnt_d   = '0;
            state_d = ST_ACTIVE;
         end

         ST_ACTIVE: begin
            s_valid_d   = '0;
            s_last_d    = '0;
            s_wd_d      = '0;
            s_control_d = '0;
            m_ready_d   = '0;
            m_rd_d      = '0;
            for (int j = 0; j < NUM_SLAVES; j++) begin
               if (sl_q == SEL_W'(j + 1)) begin
                  s_valid_d[j]   = sel_valid;
                  s_last_d[j]    = sel_last;
                  s_wd_d[j]      = sel_wd;
                  s_control_d[j] = sel_control;
               end
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
               if (ms_q == SEL_W'(i + 1)) begin
                  m_ready_d[i] = sel_ready;
                  m_rd_d[i]    = sel_rd;
               end
            end

            if (sel_valid) begin
               cnt_d = '0;
            end else if (cnt_q != TIMEOUT_C) begin
               cnt_d = cnt_q + CNT_W'(1);
            end

            // A last beat takes priority, so a release on the same cycle is never a timeout.
            if (sel_valid && sel_last) begin
               state_d = ST_RELEASE;
            end else if ((TIMEOUT > 0) && !sel_valid && (cnt_d == TIMEOUT_C)) begin
               state_d   = ST_RELEASE;
               to_flag_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            ms_d        = '0;
            sl_d        = '0;
            cnt_d       = '0;
            to_flag_d   = 1'b0;
            s_valid_d   = '0;
            s_last_d    = '0;
            s_wd_d      = '0;
            s_control_d = '0;
            m_ready_d   = '0;
            m_rd_d      = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= ST_IDLE;
         ms_q        <= '0;
         sl_q        <= '0;
         cnt_q       <= '0;
         to_flag_q   <= 1'b0;
         ack_q       <= 1'b0;
         sel_err_q   <= 1'b0;
         s_valid_q   <= '0;
         s_last_q    <= '0;
         s_wd_q      <= '0;
         s_control_q <= '0;
         m_ready_q   <= '0;
         m_rd_q      <= '0;
      end else begin
         state_q     <= state_d;
         ms_q        <= ms_d;
         sl_q        <= sl_d;
         cnt_q       <= cnt_d;
         to_flag_q   <= to_flag_d;
         ack_q       <= ack_d;
         sel_err_q   <= sel_err_d;
         s_valid_q   <= s_valid_d;
         s_last_q    <= s_last_d;
         s_wd_q      <= s_wd_d;
         s_control_q <= s_control_d;
         m_ready_q   <= m_ready_d;
         m_rd_q      <= m_rd_d;
      end
   end

   assign ack       = ack_q;
   assign sel_err   = sel_err_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_RELEASE);
   assign timeout   = (state_q == ST_RELEASE) && to_flag_q;
   assign s_valid   = s_valid_q;
   assign s_last    = s_last_q;
   assign s_wD      = s_wd_q;
   assign s_control = s_control_q;
   assign m_ready   = m_ready_q;
   assign m_rD      = m_rd_q;

endmodule

// File: tb/tb_serial_crossbar.sv
// Bench for serial_crossbar: a connection-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and randomized traffic.
module tb_serial_crossbar;

   localparam int NM = 2;
   localparam int NS = 3;
   localparam int TO = 4;
   localparam int SW = 3;

   logic          clk;
   logic          rstN;
   logic          req;
   logic [SW-1:0] master_sel, slave_sel;
   logic          ack, sel_err, busy, done, timeout;
   logic [NM-1:0] m_valid, m_last, m_wD, m_control, m_ready, m_rD;
   logic [NS-1:0] s_valid, s_last, s_wD, s_control, s_ready, s_rD;

   int errors = 0;
   int checks = 0;

   serial_crossbar #(
      .NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT(TO), .SEL_W(SW)
   ) dut (
      .clk(clk), .rstN(rstN), .req(req), .master_sel(master_sel), .slave_sel(slave_sel),
      .ack(ack), .sel_err(sel_err), .busy(busy), .done(done), .timeout(timeout),
      .m_valid(m_valid), .m_last(m_last), .m_wD(m_wD), .m_control(m_control),
      .m_ready(m_ready), .m_rD(m_rD),
      .s_valid(s_valid), .s_last(s_last), .s_wD(s_wD), .s_control(s_control),
      .s_ready(s_ready), .s_rD(s_rD)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a link record (who is connected, how long the master has been quiet,
   // whether the link closes next) and the expected value of every output.
   bit            linked, settling, closing, close_to;
   int            mi, si, quiet;
   logic          e_ack, e_err;
   logic [NS-1:0] e_s_valid, e_s_last, e_s_wd, e_s_control;
   logic [NM-1:0] e_m_ready, e_m_rd;

   task automatic model_clear_routes();
      e_s_valid = '0; e_s_last = '0; e_s_wd = '0; e_s_control = '0;
      e_m_ready = '0; e_m_rd = '0;
   endtask

   task automatic model_step();
      if (!rstN) begin
         linked = 0; settling = 0; closing = 0; close_to = 0; quiet = 0; mi = 0; si = 0;
         e_ack = 0; e_err = 0;
         model_clear_routes();
         return;
      end
      e_ack = 0;
      e_err = 0;
      if (!linked) begin
         if (req) begin
            if (master_sel >= 1 && master_sel <= NM && slave_sel >= 1 && slave_sel <= NS) begin
               linked = 1; settling = 1; quiet = 0;
               mi = int'(master_sel) - 1;
               si = int'(slave_sel) - 1;
               e_ack = 1;
            end else begin
               e_err = 1;
            end
         end
      end else if (closing) begin
         linked = 0; closing = 0; close_to = 0;
         model_clear_routes();
      end else if (settling) begin
         settling = 0;
      end else begin
         model_clear_routes();
         e_s_valid[si]   = m_valid[mi];
         e_s_last[si]    = m_last[mi];
         e_s_wd[si]      = m_wD[mi];
         e_s_control[si] = m_control[mi];
         e_m_ready[mi]   = s_ready[si];
         e_m_rd[mi]      = s_rD[si];
         quiet = m_valid[mi] ? 0 : quiet + 1;
         if (m_valid[mi] && m_last[mi]) closing = 1;
         else if (TO > 0 && quiet >= TO) begin
            closing = 1; close_to = 1;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rstN);
         model_step();
      end
   end

   always @(negedge clk) begin
      check("ack", ack, e_ack);
      check("sel_err", sel_err, e_err);
      check("busy", busy, linked);
      check("done", done, closing);
      check("timeout", timeout, closing && close_to);
      check("s_valid", s_valid, e_s_valid);
      check("s_last", s_last, e_s_last);
      check("s_wD", s_wD, e_s_wd);
      check("s_control", s_control, e_s_control);
      check("m_ready", m_ready, e_m_ready);
      check("m_rD", m_rD, e_m_rd);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req = 0; master_sel = '0; slave_sel = '0;
      m_valid = '0; m_last = '0; m_wD = '0; m_control = '0;
      s_ready = '0; s_rD = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {ack, sel_err, busy, done, timeout, m_ready, m_rD,
                             s_valid, s_last, s_wD, s_control}, '0);
   endtask

   task automatic do_reset();
      rstN = 0;
      #1;
      check_all_zero("reset");
      tick();
      tick();
      rstN = 1;
   endtask

   initial begin
      logic [3:0] pat;
      logic [2:0] rdp;
      clear_inputs();
      rstN = 1;
      #2;
      do_reset();

      // Forward transfer m2 -> s3 of bits 1,0,1,1 with noise on master 1.
      req = 1; master_sel = 3'd2; slave_sel = 3'd3;
      tick();
      check("t1_ack", ack, 1);
      check("t1_busy", busy, 1);
      req = 0; master_sel = 0; slave_sel = 0;
      tick();
      pat = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         m_valid = 2'b11; m_wD = {pat[k], ~pat[k]}; m_last = {1'b0, 1'b0} | {(k == 3), 1'b1};
         tick();
         check("t1_s_wD", s_wD, {pat[k], 2'b00});
         check("t1_s_valid", s_valid, 3'b100);
         check("t1_done", done, (k == 3));
      end
      clear_inputs();
      tick();
      check("t1_idle", {busy, done, s_wD}, '0);

      // Return path s2 -> m1.
      req = 1; master_sel = 3'd1; slave_sel = 3'd2;
      tick();
      req = 0;
      tick();
      rdp = 3'b110;
      for (int k = 0; k < 3; k++) begin
         m_valid = 2'b01;
         s_ready = 3'b110;
         s_rD = {1'b0, rdp[k], 1'b1};
         tick();
         check("t2_m_ready", m_ready, 2'b01);
         check("t2_m_rD", m_rD, {1'b0, rdp[k]});
      end
      m_last = 2'b01;
      tick();
      check("t2_done", done, 1);
      clear_inputs();
      tick();

      // Rejected selections.
      req = 1; master_sel = 3'd1; slave_sel = 3'd0;
      tick();
      check("t3_err0", {sel_err, ack, busy}, 3'b100);
      req = 0;
      tick();
      check("t3_gap", sel_err, 0);
      req = 1; slave_sel = 3'd5;
      tick();
      check("t3_err5", {sel_err, ack, busy}, 3'b100);
      req = 0;
      tick();
      check("t3_end", {sel_err, ack, busy}, 3'b000);

      // Timeout after four quiet ACTIVE cycles, then the same with a last beat on the fourth.
      req = 1; master_sel = 3'd2; slave_sel = 3'd1;
      tick();
      check("t4_ack", ack, 1);
      req = 0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         check("t4_done", done, (n == 5));
         check("t4_timeout", timeout, (n == 5));
      end
      tick();
      check("t4_idle", busy, 0);
      req = 1;
      tick();
      req = 0;
      for (int n = 1; n <= 5; n++) begin
         if (n == 5) begin
            m_valid = 2'b10; m_last = 2'b10;
         end
         tick();
         check("t4b_done", done, (n == 5));
         check("t4b_timeout", timeout, 0);
      end
      clear_inputs();
      tick();

      // Held request: ignored while linked, accepted on the first IDLE cycle.
      req = 1; master_sel = 3'd1; slave_sel = 3'd1;
      tick();
      check("t5_ack1", ack, 1);
      tick();
      master_sel = 3'd2; slave_sel = 3'd3;
      m_valid = 2'b11; m_wD = 2'b01; m_last = 2'b10;
      tick();
      check("t5_route", {s_valid, s_wD}, {3'b001, 3'b001});
      check("t5_ack_active", ack, 0);
      m_last = 2'b01;
      tick();
      check("t5_release", {done, ack}, 2'b10);
      m_valid = 0; m_last = 0; m_wD = 0;
      tick();
      check("t5_idle", {busy, ack}, 2'b00);
      tick();
      check("t5_ack2", ack, 1);
      req = 0;
      tick();
      m_valid = 2'b10; m_last = 2'b10;
      tick();
      check("t5_done2", done, 1);
      clear_inputs();
      tick();

      // Reset while ACTIVE with a beat in flight.
      req = 1; master_sel = 3'd1; slave_sel = 3'd1;
      tick();
      req = 0;
      tick();
      m_valid = 2'b01; m_wD = 2'b01;
      tick();
      check("t6_beat", s_valid, 3'b001);
      rstN = 0;
      #1;
      check_all_zero("t6_async");
      tick();
      tick();
      rstN = 1;
      for (int n = 0; n < 6; n++) begin
         tick();
         check("t6_after", {done, busy}, 2'b00);
      end
      clear_inputs();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         req        = ($urandom_range(0, 3) == 0);
         master_sel = SW'($urandom_range(0, 3));
         slave_sel  = SW'($urandom_range(0, 4));
         m_valid    = NM'($urandom);
         m_last     = NM'(($urandom_range(0, 5) == 0) ? $urandom : 0);
         m_wD       = NM'($urandom);
         m_control  = NM'($urandom);
         s_ready    = NS'($urandom);
         s_rD       = NS'($urandom);
         if (c == 1500) begin
            rstN = 0;
            #1;
            check_all_zero("rand_reset");
            rstN = 1;
         end
         tick();
      end

      clear_inputs();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
